// File: rtl/warx_dec_round_ctrl_if.sv
// Request/response handshake bundle for the WARX decryption round controller.
// The controller takes the slave view; whoever feeds it ciphertext takes the master view.
interface warx_dec_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_o;

  modport master (
    output in_valid, data_i, out_ready,
    input  in_ready, out_valid, data_o
  );

  modport slave (
    input  in_valid, data_i, out_ready,
    output in_ready, out_valid, data_o
  );
endinterface

// File: rtl/warx_dec_round_ctrl.sv
// Iterative round controller for the 128-bit WARX decryption layer: holds the state,
// applies the external layer STEPS times per round, adds round keys and rotates lanes.
module warx_dec_round_ctrl #(
  parameter int NUM_ROUNDS = 4,
  parameter int STEPS      = 2,
  parameter int LANE_ROT   = 1,
  parameter int RW         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  warx_dec_round_ctrl_if.slave bus,
  output logic                 busy_o,
  output logic [RW-1:0]        rnd_idx_o,
  input  logic [127:0]         rk_i,
  output logic [127:0]         warx_i,
  input  logic [127:0]         warx_o
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state, w_state_next;
  logic [127:0]   r_data, w_data_next;
  logic [RW-1:0]  r_round, w_round_next;
  logic [SW-1:0]  r_step, w_step_next;
  logic [127:0]   w_rot;
  logic           w_last_step;

  // Inter-round rotation: lane k moves to lane (k+LANE_ROT) mod 8.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign w_rot[16*((gi+LANE_ROT)%8) +: 16] = warx_o[16*gi +: 16];
  end

  assign w_last_step = (r_step == SW'(STEPS-1));

  // Kept outside the FSM block so the key-store and layer loops stay acyclic.
  assign rnd_idx_o = (r_state == RUN) ? r_round : '0;
  assign warx_i    = (r_state == RUN && r_step == '0) ? (r_data ^ rk_i) : r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_round <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_round <= w_round_next;
      r_step  <= w_step_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_data_next   = r_data;
    w_round_next  = r_round;
    w_step_next   = r_step;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.data_o    = r_data;
    busy_o        = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_data_next  = bus.data_i;
          w_round_next = RW'(NUM_ROUNDS-1);
          w_step_next  = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (!w_last_step) begin
          w_data_next = warx_o;
          w_step_next = r_step + SW'(1);
        end else if (r_round != '0) begin
          w_data_next  = w_rot;
          w_round_next = r_round - RW'(1);
          w_step_next  = '0;
        end else begin
          // Final round: no trailing rotation.
          w_data_next  = warx_o;
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy_o        = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
